// File: rtl/mac_pkg.sv
// mac_pkg: shared state encoding and drain-timing helpers for the MAC sequencer.
// No ports; imported by mac_sequencer and mac_seq_delay.
package mac_pkg;
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] ISSUE = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] ABORT = 3'd5;

    localparam int MacLatencyDef = 2;
    localparam int PipeStagesDef = 5;

    // Cycles from the last AccEn to the final sum on the output pipeline DataOut.
    function automatic int drainCycles(input int macLatency, input int pipeStages);
        return macLatency + pipeStages + 1;
    endfunction

    localparam int DrainCycles = drainCycles(MacLatencyDef, PipeStagesDef);
    localparam int CntWidth    = $clog2(DrainCycles + 1);
endpackage

// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: host command and datapath control bundle of the MAC sequencer.
// Start/Len/Abort come from the host; Busy/RdEn/RdAddr/AccEn/AccClr/PipeSclr/ResultValid
// are driven by the sequencer (master modport) and consumed by host/datapath (slave modport).
interface mac_sequencer_if #(
    parameter int AddrWidth = 8,
    parameter int LenWidth  = 8
);
    logic                 Start;
    logic [LenWidth-1:0]  Len;
    logic                 Abort;
    logic                 Busy;
    logic                 RdEn;
    logic [AddrWidth-1:0] RdAddr;
    logic                 AccEn;
    logic                 AccClr;
    logic                 PipeSclr;
    logic                 ResultValid;

    modport master (
        input  Start, Len, Abort,
        output Busy, RdEn, RdAddr, AccEn, AccClr, PipeSclr, ResultValid
    );

    modport slave (
        output Start, Len, Abort,
        input  Busy, RdEn, RdAddr, AccEn, AccClr, PipeSclr, ResultValid
    );
endinterface

// File: rtl/mac_seq_delay.sv
// mac_seq_delay: one-cycle register stage turning RdEn/first-issue into AccEn/AccClr.
// Ports: clk, rst_n (async active-low), kill (abort accepted this cycle),
//        rdEn, first (first read of a pass) in; accEn, accClr out.
module mac_seq_delay (
    input  logic clk,
    input  logic rst_n,
    input  logic kill,
    input  logic rdEn,
    input  logic first,
    output logic accEn,
    output logic accClr
);
    // The read issued in an abort cycle must not reach the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accEn  <= 1'b0;
            accClr <= 1'b0;
        end else begin
            accEn  <= rdEn && !kill;
            accClr <= first && !kill;
        end
    end
endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: sequences one multiply-accumulate pass of Len operand pairs.
// Ports: clk, rst_n (async active-low), bus (mac_sequencer_if.master): Start/Len/Abort
//        command in; Busy, RdEn/RdAddr, AccEn/AccClr, PipeSclr, ResultValid out.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int AddrWidth  = 8,
    parameter int LenWidth   = 8,
    parameter int MacLatency = MacLatencyDef,
    parameter int PipeStages = PipeStagesDef
) (
    input logic           clk,
    input logic           rst_n,
    mac_sequencer_if.master bus
);
    localparam int Drain = drainCycles(MacLatency, PipeStages);
    localparam int CntW  = $clog2(Drain + 1);

    logic [2:0]           state, nextState;
    logic [LenWidth-1:0]  lenReg;
    logic [CntW-1:0]      cnt;
    logic [AddrWidth-1:0] rdAddr, lastAddr;
    logic                 busy, rdEn, pipeSclr, resultValid, aborting;

    assign lastAddr = AddrWidth'(lenReg - LenWidth'(1));
    // DONE and the abort-clear cycle already head back to IDLE, so Abort is ignored there.
    assign aborting = bus.Abort && (state == CLEAR || state == ISSUE || state == DRAIN);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = (bus.Start && bus.Len != '0) ? CLEAR : IDLE;
            CLEAR:   nextState = ISSUE;
            ISSUE:   nextState = (rdAddr == lastAddr) ? DRAIN : ISSUE;
            DRAIN:   nextState = (cnt == '0) ? DONE : DRAIN;
            default: nextState = IDLE;
        endcase
        if (aborting) nextState = ABORT;
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lenReg      <= '0;
            cnt         <= '0;
            rdAddr      <= '0;
            busy        <= 1'b0;
            rdEn        <= 1'b0;
            pipeSclr    <= 1'b0;
            resultValid <= 1'b0;
        end else begin
            state       <= nextState;
            if (state == IDLE && nextState == CLEAR) lenReg <= bus.Len;
            if (nextState == ISSUE) rdAddr <= (state == ISSUE) ? rdAddr + AddrWidth'(1) : '0;
            // Entering DRAIN coincides with the last AccEn; Drain-1 more cycles precede DONE.
            cnt         <= (nextState != DRAIN) ? '0 : (state == DRAIN) ? cnt - CntW'(1) : CntW'(Drain - 1);
            busy        <= nextState != IDLE;
            rdEn        <= nextState == ISSUE;
            pipeSclr    <= nextState == CLEAR || nextState == ABORT;
            resultValid <= nextState == DONE;
        end
    end

    mac_seq_delay uDelay (
        .clk    (clk),
        .rst_n  (rst_n),
        .kill   (aborting),
        .rdEn   (rdEn),
        .first  (rdEn && rdAddr == '0),
        .accEn  (bus.AccEn),
        .accClr (bus.AccClr)
    );

    assign bus.Busy        = busy;
    assign bus.RdEn        = rdEn;
    assign bus.RdAddr      = rdAddr;
    assign bus.PipeSclr    = pipeSclr;
    assign bus.ResultValid = resultValid;
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: randomized and directed scoreboard bench for mac_sequencer.
module tb_mac_sequencer;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_sequencer_if #(.AddrWidth(8), .LenWidth(8)) bus ();

    mac_sequencer #(.AddrWidth(8), .LenWidth(8), .MacLatency(2), .PipeStages(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { int c; int a; } rd_t;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  t0 = -100;
    int  pl = 1;
    int  ab = -1;
    int  endC = -1;
    rd_t rdQ[$];
    int  rvQ[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", n, cyc, act, exp);
        end
    endtask

    // Expected {Busy,RdEn,AccEn,AccClr,PipeSclr,ResultValid} at cycle c for the current pass.
    function automatic logic [5:0] expSig(input int c);
        int lim;
        logic busy, rd, acc, clr, sclr, rv;
        lim  = (ab >= 0) ? ab : 32'h3fffffff;
        busy = c >= t0 + 1 && c <= endC;
        rd   = c >= t0 + 2 && c <= t0 + pl + 1 && c <= lim;
        acc  = c >= t0 + 3 && c <= t0 + pl + 2 && c <= lim;
        clr  = acc && c == t0 + 3;
        sclr = c == t0 + 1 || (ab >= 0 && c == ab + 1);
        rv   = ab < 0 && c == t0 + pl + 2 + D;
        return {busy, rd, acc, clr, sclr, rv};
    endfunction

    task automatic modelReset();
        t0 = -100; pl = 1; ab = -1; endC = -1;
        rdQ.delete();
        rvQ.delete();
    endtask

    task automatic step(input bit s, input int l, input bit a);
        bus.Start = s;
        bus.Len   = 8'(l);
        bus.Abort = a;
        if (a && ab < 0 && cyc >= t0 + 1 && cyc <= t0 + pl + 1 + D) begin
            ab   = cyc;
            endC = cyc + 1;
            void'(rvQ.pop_back());
            while (rdQ.size() > 0 && rdQ[$].c > cyc) void'(rdQ.pop_back());
        end
        if (s && l != 0 && cyc > endC) begin
            t0 = cyc; pl = l; ab = -1; endC = cyc + l + 2 + D;
            rvQ.push_back(cyc + l + 2 + D);
            for (int i = 0; i < l; i++) rdQ.push_back('{c: cyc + 2 + i, a: i});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 1'b0);
    endtask

    always @(negedge clk) begin : monitor
        logic [5:0] e;
        rd_t r;
        int v;
        if (rst_n) begin
            e = expSig(cyc);
            chk("busy", 32'(bus.Busy), 32'(e[5]));
            chk("rden", 32'(bus.RdEn), 32'(e[4]));
            chk("accen", 32'(bus.AccEn), 32'(e[3]));
            chk("accclr", 32'(bus.AccClr), 32'(e[2]));
            chk("pipesclr", 32'(bus.PipeSclr), 32'(e[1]));
            chk("resultvalid", 32'(bus.ResultValid), 32'(e[0]));
            if (bus.RdEn === 1'b1) begin
                if (rdQ.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
                else begin
                    r = rdQ.pop_front();
                    chk("rd_cycle", 32'(cyc), 32'(r.c));
                    chk("rd_addr", 32'(bus.RdAddr), 32'(r.a));
                end
            end
            if (bus.ResultValid === 1'b1) begin
                if (rvQ.size() == 0) chk("rv_unexpected", 32'd1, 32'd0);
                else begin
                    v = rvQ.pop_front();
                    chk("rv_cycle", 32'(cyc), 32'(v));
                end
            end
        end
    end

    initial begin
        bus.Start = 1'b0;
        bus.Len   = '0;
        bus.Abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);
        step(1'b1, 4, 1'b0); idle(20);
        step(1'b1, 0, 1'b0); idle(5);
        step(1'b1, 1, 1'b0); idle(15);
        step(1'b1, 4, 1'b0); idle(3); step(1'b1, 9, 1'b0); idle(10); step(1'b1, 3, 1'b0); idle(20);
        step(1'b1, 8, 1'b0); idle(4); step(1'b0, 0, 1'b1); idle(30);
        step(1'b1, 8, 1'b0); idle(11); step(1'b0, 0, 1'b1); idle(30);
        step(1'b1, 2, 1'b0); idle(11); step(1'b0, 0, 1'b1); idle(5);
        step(1'b1, 3, 1'b1); idle(20);
        step(1'b1, 255, 1'b0); idle(270);
        step(1'b1, 6, 1'b0); idle(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_rden", 32'(bus.RdEn), 32'd0);
        chk("rst_rdaddr", 32'(bus.RdAddr), 32'd0);
        chk("rst_accen", 32'(bus.AccEn), 32'd0);
        chk("rst_accclr", 32'(bus.AccClr), 32'd0);
        chk("rst_pipesclr", 32'(bus.PipeSclr), 32'd0);
        chk("rst_resultvalid", 32'(bus.ResultValid), 32'd0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(20);
        repeat (400) begin
            bit s, a;
            int l;
            s = $urandom_range(0, 3) == 0;
            l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 24));
            a = $urandom_range(0, 29) == 0;
            step(s, l, a);
        end
        idle(40);
        chk("rdq_empty", 32'(rdQ.size()), 32'd0);
        chk("rvq_empty", 32'(rvQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Controller that sequences one multiply-accumulate pass of Len operand pairs through the MAC datapath.
- Issues operand-memory reads, drives accumulator enable and first-element clear, and owns the synchronous clear of the output data pipeline.
- Counts out the MAC and output-pipeline latency, then pulses ResultValid exactly when the final sum appears at the output pipeline's DataOut.
- Sits between the host/command interface and the operand memories, the MAC core and the output pipeline.

Parameters:
- AddrWidth, 8: operand-memory address width.
- LenWidth, 8: width of Len. Must satisfy LenWidth <= AddrWidth.
- MacLatency, 2: cycles from an AccEn cycle to that sum being registered at the accumulator output.
- PipeStages, 5: Stages setting of the output data pipeline. That pipeline's latency is PipeStages+1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Start  input  1  command strobe; sampled only in IDLE.
- Len  input  LenWidth  number of operand pairs; sampled with Start.
- Abort  input  1  cancel the current pass.
- Busy  output  1  high from the cycle after an accepted Start until the cycle after ResultValid or abort completion.
- RdEn  output  1  operand-memory read enable; read data is valid the next cycle.
- RdAddr  output  AddrWidth  operand address, 0..Len-1.
- AccEn  output  1  MAC accumulate enable; equals RdEn delayed one cycle.
- AccClr  output  1  high with the first AccEn of a pass; the MAC loads the product instead of accumulating.
- PipeSclr  output  1  drives the output pipeline's sclr.
- ResultValid  output  1  one-cycle pulse when the final sum is on the pipeline DataOut.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. Busy, RdEn, AccEn, AccClr, PipeSclr and ResultValid are all 0; RdAddr=0; counters=0. All outputs are registered.
- States: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE: Start=1 with Len!=0 latches Len and goes to CLEAR. Start with Len==0 is ignored; the block stays in IDLE with Busy=0.
- CLEAR (1 cycle): PipeSclr=1, Busy=1, then go to ISSUE.
- ISSUE (exactly Len cycles):
  - RdEn=1; RdAddr=0,1,...,Len-1, incrementing by one each cycle. No wrap within a pass; Len=2^LenWidth-1 reaches address Len-1.
  - After the cycle with RdAddr=Len-1, go to DRAIN. RdAddr holds its last value until the next pass, which restarts at 0.
- AccEn: RdEn delayed one register. AccClr is 1 only in the first AccEn cycle of a pass.
- DRAIN:
  - Down-counter holds for D = MacLatency + PipeStages + 1 cycles, counted from the last AccEn cycle.
  - ResultValid=1 in cycle (last AccEn cycle + D) and in that cycle only. The state for that cycle is DONE.
- DONE (1 cycle): ResultValid=1, Busy=1; then go to IDLE. Busy=0 in the following cycle.
- Start while Busy is ignored: no queuing, Len is not re-sampled.
- Abort (any state except IDLE):
  - Next cycle: state=CLEAR-abort, RdEn=0, AccEn=0, AccClr=0, PipeSclr=1, ResultValid=0.
  - The cycle after: IDLE with Busy=0.
  - Abort in IDLE has no effect. Abort and Start together in IDLE: Start wins.
  - Abort in the cycle ResultValid is high: ResultValid is still delivered; the FSM returns to IDLE normally.
- Reset mid-pass: immediate return to reset values. No ResultValid; the pipeline contents are not relied upon.
- ResultValid is never asserted for an aborted pass, including one aborted while in DRAIN.

Decomposition:
- Shared package mac_pkg holds:
  - state encoding: IDLE=0, CLEAR=1, ISSUE=2, DRAIN=3, DONE=4, plus abort-clear state ABORT=5, 3-bit;
  - localparam DrainCycles = MacLatency + PipeStages + 1;
  - counter width $clog2(DrainCycles+1).
- One sub-module, mac_seq_delay: a 1-bit register chain with async reset that generates AccEn/AccClr from RdEn/first-issue.
- The FSM, address counter and drain counter stay in mac_sequencer.

Test Plan:
- Reset/idle: assert rst_n=0 mid-cycle -> all outputs 0 immediately. After release with no Start for 20 cycles -> all outputs stay 0.
- Basic pass (MacLatency=2, PipeStages=5), Start with Len=4 at cycle 0:
  - PipeSclr=1 at cycle 1;
  - RdEn cycles 2-5 with RdAddr 0,1,2,3;
  - AccEn cycles 3-6, AccClr at cycle 3 only;
  - ResultValid at cycle 14 only; Busy 1 for cycles 1-14, 0 at cycle 15.
- Boundaries: Start with Len=0 -> Busy stays 0, no RdEn. Start with Len=1 -> one RdEn (addr 0), AccEn=AccClr at cycle 3, ResultValid at cycle 11.
- Busy-ignore: Len=4 at cycle 0, second Start with Len=9 at cycle 4 -> exactly 4 reads, ResultValid at cycle 14. A new Start at cycle 15 is accepted.
- Abort: Len=8, Abort at cycle 5 -> RdEn=0 and PipeSclr=1 at cycle 6, Busy=0 at cycle 7, no ResultValid over the next 30 cycles. Repeat with the abort in DRAIN -> same result.
- Max length: Len=255 -> RdAddr 0..254 with no wrap, 255 AccEn cycles, ResultValid exactly 8 cycles after the last AccEn.
